// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 serial transmitter: byte FIFO feeding an LSB-first shifter.
// Optional even-parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV    = 106,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          in_ready,
    output logic                          ser_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLK_DIV);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ser_q, ser_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif
    logic [7:0]        mem [FIFO_DEPTH];
    logic              push;
    logic              pop;
    logic              baud_end;

    assign in_ready   = (count_q < CNT_W'(FIFO_DEPTH));
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign ser_tx     = ser_q;

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ser_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ser_q    <= ser_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        rd_ptr_d = rd_ptr_q;
        pop      = 1'b0;
        push     = in_valid && in_ready;
        baud_end = (baud_q == BAUD_W'(CLK_DIV - 1));
        baud_d   = baud_end ? '0 : baud_q + BAUD_W'(1);
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (baud_end) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            shift_d  = mem[rd_ptr_q];
            bit_d    = '0;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem[rd_ptr_q];
`endif
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        // Line level follows the state being entered so it changes on the edge.
        case (state_d)
            S_START: ser_d = 1'b0;
            S_DATA:  ser_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: ser_d = parity_d;
`endif
            default: ser_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: line decoder monitors plus a byte scoreboard.
// Two instances: slow baud (106) for timing checks, fast baud (4) for streaming.
module tb_uart_tx_fifo;

    localparam int unsigned DIV_A = 106;
    localparam int unsigned DIV_B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int FRAME_A = int'(NBITS * DIV_A);
    localparam int FRAME_B = int'(NBITS * DIV_B);

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid_a, in_valid_b;
    logic [7:0] in_data_a, in_data_b;
    logic       in_ready_a, in_ready_b;
    logic       ser_a, ser_b;
    logic       busy_a, busy_b;
    logic [3:0] fifo_count_a, fifo_count_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fe       = 0;
    int max_b    = 0;

    logic [7:0] rx_a[$];
    logic [7:0] rx_b[$];
    int         st_a[$];
    logic       par_a[$];

    uart_tx_fifo #(.CLK_DIV(DIV_A), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .resetn(resetn), .in_valid(in_valid_a), .in_data(in_data_a),
        .in_ready(in_ready_a), .ser_tx(ser_a), .busy(busy_a), .fifo_count(fifo_count_a)
    );

    uart_tx_fifo #(.CLK_DIV(DIV_B), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .resetn(resetn), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .ser_tx(ser_b), .busy(busy_b), .fifo_count(fifo_count_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (int'(fifo_count_b) > max_b) max_b <= int'(fifo_count_b);
    end

    // Line decoder: finds a start bit, samples each bit at its middle.
    task automatic mon(input bit sel, input int unsigned div);
        logic [7:0] d;
        logic       p;
        int         t;
        forever begin
            do @(negedge clk); while ((sel ? ser_b : ser_a) !== 1'b0);
            t = cyc;
            repeat (div / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (div) @(negedge clk);
                d[i] = sel ? ser_b : ser_a;
            end
            p = 1'b0;
`ifdef UART_TX_PARITY_EN
            repeat (div) @(negedge clk);
            p = sel ? ser_b : ser_a;
`endif
            repeat (div) @(negedge clk);
            if ((sel ? ser_b : ser_a) !== 1'b1) fe++;
            if (sel) begin
                rx_b.push_back(d);
            end else begin
                rx_a.push_back(d);
                st_a.push_back(t);
                par_a.push_back(p);
            end
        end
    endtask

    initial mon(1'b0, DIV_A);
    initial mon(1'b1, DIV_B);

    // Offer one byte (called at a negedge); returns the edge index that accepted it.
    task automatic push(input bit sel, input logic [7:0] b, input int budget, output int edge_o);
        int   n;
        logic acc;
        n      = 0;
        edge_o = -1;
        if (sel) begin in_valid_b = 1'b1; in_data_b = b; end
        else     begin in_valid_a = 1'b1; in_data_a = b; end
        do begin
            acc = sel ? in_ready_b : in_ready_a;
            @(negedge clk);
            n++;
        end while (!acc && n < budget);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        checks++;
        if (acc !== 1'b1) begin
            failures++;
            $display("FAIL push_accept sel=%0d byte=%h accepted=%b required=1", sel, b, acc);
        end else begin
            edge_o = cyc;
        end
    endtask

    task automatic wait_rx_a(input int k, input int budget);
        int n;
        n = 0;
        while (rx_a.size() < k && n < budget) begin @(negedge clk); n++; end
        checks++;
        if (rx_a.size() < k) begin
            failures++;
            $display("FAIL rx_a_count got=%0d required=%0d", rx_a.size(), k);
        end
    endtask

    task automatic wait_idle_a(input int budget, output int t);
        int n;
        n = 0;
        while (busy_a !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        t = cyc;
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL busy_a_timeout got=%b required=0", busy_a);
        end
    endtask

    task automatic clear_q();
        rx_a.delete(); rx_b.delete(); st_a.delete(); par_a.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        in_data_a = 8'h00; in_data_b = 8'h00;
        repeat (3) @(negedge clk);
        checks += 8;
        if (ser_a !== 1'b1) begin failures++; $display("FAIL rst_ser_a got=%b required=1", ser_a); end
        if (busy_a !== 1'b0) begin failures++; $display("FAIL rst_busy_a got=%b required=0", busy_a); end
        if (in_ready_a !== 1'b1) begin failures++; $display("FAIL rst_ready_a got=%b required=1", in_ready_a); end
        if (fifo_count_a !== 4'd0) begin failures++; $display("FAIL rst_count_a got=%0d required=0", fifo_count_a); end
        if (ser_b !== 1'b1) begin failures++; $display("FAIL rst_ser_b got=%b required=1", ser_b); end
        if (busy_b !== 1'b0) begin failures++; $display("FAIL rst_busy_b got=%b required=0", busy_b); end
        if (in_ready_b !== 1'b1) begin failures++; $display("FAIL rst_ready_b got=%b required=1", in_ready_b); end
        if (fifo_count_b !== 4'd0) begin failures++; $display("FAIL rst_count_b got=%0d required=0", fifo_count_b); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int   e, t, tb_end;
        logic [7:0] d;
        clear_q();
        push(1'b0, 8'h55, 4, e);
        checks += 2;
        if (fifo_count_a !== 4'd1) begin failures++; $display("FAIL single_count_after_push got=%0d required=1", fifo_count_a); end
        if (ser_a !== 1'b1) begin failures++; $display("FAIL single_line_before_pop got=%b required=1", ser_a); end
        @(negedge clk);
        checks += 3;
        if (ser_a !== 1'b0) begin failures++; $display("FAIL single_start_low got=%b required=0", ser_a); end
        if (fifo_count_a !== 4'd0) begin failures++; $display("FAIL single_count_after_pop got=%0d required=0", fifo_count_a); end
        if (busy_a !== 1'b1) begin failures++; $display("FAIL single_busy got=%b required=1", busy_a); end
        wait_rx_a(1, 3 * FRAME_A);
        if (rx_a.size() > 0) begin
            d = rx_a.pop_front();
            t = st_a.pop_front();
            checks += 2;
            if (d !== 8'h55) begin failures++; $display("FAIL single_byte got=%h required=55", d); end
            if (t != e + 1) begin failures++; $display("FAIL single_start_edge got=%0d required=%0d", t, e + 1); end
            wait_idle_a(2 * FRAME_A, tb_end);
            checks++;
            if (tb_end - t != FRAME_A) begin
                failures++;
                $display("FAIL single_busy_len got=%0d required=%0d", tb_end - t, FRAME_A);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        int e [3];
        int t0, t2, tend;
        exp[0] = 8'h48; exp[1] = 8'h69; exp[2] = 8'h0A;
        clear_q();
        for (int i = 0; i < 3; i++) push(1'b0, exp[i], 4, e[i]);
        checks++;
        if (e[1] != e[0] + 1 || e[2] != e[0] + 2) begin
            failures++;
            $display("FAIL b2b_push_edges got=%0d,%0d,%0d required_consecutive", e[0], e[1], e[2]);
        end
        wait_rx_a(3, 4 * FRAME_A);
        if (rx_a.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_a[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL b2b_byte%0d got=%h required=%h", i, rx_a[i], exp[i]);
                end
            end
            t0 = st_a[0];
            t2 = st_a[2];
            checks += 2;
            if (t0 != e[0] + 1) begin failures++; $display("FAIL b2b_first_start got=%0d required=%0d", t0, e[0] + 1); end
            if (t2 - t0 != 2 * FRAME_A) begin failures++; $display("FAIL b2b_gap got=%0d required=%0d", t2 - t0, 2 * FRAME_A); end
            wait_idle_a(2 * FRAME_A, tend);
            checks++;
            if (tend - t0 != 3 * FRAME_A) begin
                failures++;
                $display("FAIL b2b_total_len got=%0d required=%0d", tend - t0, 3 * FRAME_A);
            end
        end
    endtask

    task automatic test_full_fifo();
        int   e [10];
        int   p, tend;
        logic stall_ok, consec;
        clear_q();
        for (int k = 0; k < 9; k++) push(1'b0, 8'(k), 4, e[k]);
        consec = 1'b1;
        for (int k = 1; k < 9; k++) if (e[k] != e[0] + k) consec = 1'b0;
        checks += 3;
        if (!consec) begin failures++; $display("FAIL full_consecutive got=0 required=1"); end
        if (fifo_count_a !== 4'd8) begin failures++; $display("FAIL full_count got=%0d required=8", fifo_count_a); end
        if (in_ready_a !== 1'b0) begin failures++; $display("FAIL full_ready got=%b required=0", in_ready_a); end
        // Second pop happens one frame after the first (at e[0]+1).
        p = e[0] + 1 + FRAME_A;
        stall_ok = 1'b1;
        while (cyc < p) begin
            if (in_ready_a !== 1'b0 || fifo_count_a !== 4'd8) stall_ok = 1'b0;
            @(negedge clk);
        end
        checks += 3;
        if (!stall_ok) begin failures++; $display("FAIL full_stall got=0 required=1"); end
        if (fifo_count_a !== 4'd7) begin failures++; $display("FAIL full_count_after_pop got=%0d required=7", fifo_count_a); end
        if (in_ready_a !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b required=1", in_ready_a); end
        push(1'b0, 8'h09, 4, e[9]);
        checks++;
        if (e[9] != p + 1) begin failures++; $display("FAIL full_late_accept got=%0d required=%0d", e[9], p + 1); end
        wait_rx_a(10, 11 * FRAME_A);
        if (rx_a.size() >= 10) begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (rx_a[k] !== 8'(k)) begin
                    failures++;
                    $display("FAIL full_byte%0d got=%h required=%h", k, rx_a[k], 8'(k));
                end
            end
        end
        wait_idle_a(2 * FRAME_A, tend);
    endtask

    task automatic test_reset_mid();
        int   e, e2, tgt, tend;
        logic [7:0] d;
        clear_q();
        push(1'b0, 8'hF0, 4, e);
        for (int k = 0; k < 4; k++) push(1'b0, 8'($urandom), 4, e2);
        tgt = e + 1 + 4 * int'(DIV_A) + int'(DIV_A) / 2;
        while (cyc < tgt) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checks += 4;
        if (ser_a !== 1'b1) begin failures++; $display("FAIL midrst_ser got=%b required=1", ser_a); end
        if (fifo_count_a !== 4'd0) begin failures++; $display("FAIL midrst_count got=%0d required=0", fifo_count_a); end
        if (busy_a !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b required=0", busy_a); end
        if (in_ready_a !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b required=1", in_ready_a); end
        resetn = 1'b1;
        repeat (12 * DIV_A) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL midrst_stays_idle got=%b required=0", busy_a); end
        clear_q();
        push(1'b0, 8'h33, 4, e);
        wait_rx_a(1, 3 * FRAME_A);
        wait_idle_a(2 * FRAME_A, tend);
        repeat (FRAME_A) @(negedge clk);
        checks++;
        if (rx_a.size() != 1) begin
            failures++;
            $display("FAIL midrst_frames got=%0d required=1", rx_a.size());
        end
        if (rx_a.size() > 0) begin
            d = rx_a[0];
            checks++;
            if (d !== 8'h33) begin failures++; $display("FAIL midrst_byte got=%h required=33", d); end
        end
    endtask

    task automatic test_wrap();
        int n, e;
        clear_q();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            push(1'b1, 8'hA0 + 8'(i), 12 * FRAME_B, e);
        end
        n = 0;
        while (rx_b.size() < 20 && n < 25 * FRAME_B) begin @(negedge clk); n++; end
        checks++;
        if (rx_b.size() != 20) begin failures++; $display("FAIL wrap_count got=%0d required=20", rx_b.size()); end
        for (int i = 0; i < 20 && i < rx_b.size(); i++) begin
            checks++;
            if (rx_b[i] !== 8'hA0 + 8'(i)) begin
                failures++;
                $display("FAIL wrap_byte%0d got=%h required=%h", i, rx_b[i], 8'hA0 + 8'(i));
            end
        end
        checks++;
        if (max_b > 8) begin failures++; $display("FAIL wrap_max_count got=%0d required_le=8", max_b); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] v [2];
        logic       pexp [2];
        int e, tend, t;
        v[0] = 8'h07; pexp[0] = 1'b1;
        v[1] = 8'h03; pexp[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clear_q();
            push(1'b0, v[i], 4, e);
            wait_rx_a(1, 3 * FRAME_A);
            wait_idle_a(2 * FRAME_A, tend);
            if (rx_a.size() > 0) begin
                t = st_a[0];
                checks += 3;
                if (rx_a[0] !== v[i]) begin failures++; $display("FAIL parity_byte got=%h required=%h", rx_a[0], v[i]); end
                if (par_a[0] !== pexp[i]) begin failures++; $display("FAIL parity_bit got=%b required=%b", par_a[0], pexp[i]); end
                if (tend - t != 11 * int'(DIV_A)) begin
                    failures++;
                    $display("FAIL parity_len got=%0d required=%0d", tend - t, 11 * int'(DIV_A));
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_fifo();
        test_reset_mid();
        test_wrap();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (fe != 0) begin failures++; $display("FAIL stop_bits bad=%0d required=0", fe); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
